// File: rtl/fifo_axis_drain.sv
// Fifo read-side drain: pops show-ahead fifo words into a registered AXI4-Stream master.
// Packet framing tags tlast at pop time; a skid register decouples tready from fifo_rd.
module fifo_axis_drain #(
    parameter int DATA_BITS = 64,
    parameter int LEN_BITS  = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    output logic                 fifo_rd,
    input  logic                 fifo_ready_rd,
    input  logic [DATA_BITS-1:0] fifo_data,
    input  logic [LEN_BITS-1:0]  pkt_beats,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [DATA_BITS-1:0] m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic                 pkt_done
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [LEN_BITS-1:0] ONE = LEN_BITS'(1);

    state_t               state_q, state_d;
    logic [LEN_BITS-1:0]  beat_cnt_q, beat_cnt_d;
    logic [LEN_BITS-1:0]  len_q, len_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_last_q, out_last_d;
    logic [DATA_BITS-1:0] out_data_q, out_data_d;
    logic                 skid_valid_q, skid_valid_d;
    logic                 skid_last_q, skid_last_d;
    logic [DATA_BITS-1:0] skid_data_q, skid_data_d;
    logic                 pkt_done_q, pkt_done_d;

    logic                 pop;
    logic                 hs;
    logic                 pop_last;
    logic [LEN_BITS-1:0]  len_eff;

    // fifo_rd depends only on the registered skid state, never on tready
    assign fifo_rd = fifo_ready_rd && !skid_valid_q && !areset;
    assign pop     = fifo_rd && fifo_ready_rd;
    assign hs      = out_valid_q && m_axis_tready;
    assign len_eff = (pkt_beats == '0) ? ONE : pkt_beats;

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        pop_last   = 1'b0;
        if (pop) begin
            if (state_q == IDLE) begin
                len_d = len_eff;
                if (len_eff == ONE) begin
                    pop_last = 1'b1;
                end else begin
                    beat_cnt_d = ONE;
                    state_d    = ACTIVE;
                end
            end else if (beat_cnt_q == len_q - ONE) begin
                pop_last   = 1'b1;
                beat_cnt_d = '0;
                state_d    = IDLE;
            end else begin
                beat_cnt_d = beat_cnt_q + ONE;
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_last_d  = skid_last_q;
        skid_data_d  = skid_data_q;
        pkt_done_d   = hs && out_last_q;
        if (hs) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_last_d   = skid_last_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (pop) begin
            if (!out_valid_q || (hs && !skid_valid_q)) begin
                out_valid_d = 1'b1;
                out_data_d  = fifo_data;
                out_last_d  = pop_last;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = fifo_data;
                skid_last_d  = pop_last;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            len_q        <= ONE;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_last_q  <= 1'b0;
            skid_data_q  <= '0;
            pkt_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            len_q        <= len_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_last_q  <= skid_last_d;
            skid_data_q  <= skid_data_d;
            pkt_done_q   <= pkt_done_d;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tlast  = out_last_q;
    assign busy          = (state_q == ACTIVE);
    assign pkt_done      = pkt_done_q;

endmodule

// File: tb/tb_fifo_axis_drain.sv
// Bench for fifo_axis_drain: fifo model, packet framing model and scoreboard.
module tb_fifo_axis_drain;

    logic        aclk = 1'b0;
    logic        areset;
    logic        fifo_rd;
    logic        fifo_ready_rd;
    logic [63:0] fifo_data;
    logic [15:0] pkt_beats;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        busy;
    logic        pkt_done;

    fifo_axis_drain #(.DATA_BITS(64), .LEN_BITS(16)) dut (
        .aclk(aclk),
        .areset(areset),
        .fifo_rd(fifo_rd),
        .fifo_ready_rd(fifo_ready_rd),
        .fifo_data(fifo_data),
        .pkt_beats(pkt_beats),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .pkt_done(pkt_done)
    );

    always #5 aclk = ~aclk;

    int          nchk = 0;
    int          nerr = 0;
    logic [63:0] fifo_m[$];
    logic [64:0] sb[$];
    int          m_len = 1;
    int          m_idx = 0;
    int          npop = 0;
    int          ndone = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: drive fifo inputs, model pop/handshake, step past posedge.
    task automatic cycle();
        logic        pop, hs, rst, p_tv, p_tr, p_l, p_done;
        logic [63:0] p_d;
        logic [64:0] e;
        bit          last;
        fifo_ready_rd = (fifo_m.size() != 0);
        fifo_data     = fifo_ready_rd ? fifo_m[0] : 64'h0;
        #1;
        rst    = areset;
        pop    = fifo_rd && fifo_ready_rd;
        hs     = m_axis_tvalid && m_axis_tready;
        p_tv   = m_axis_tvalid;
        p_tr   = m_axis_tready;
        p_d    = m_axis_tdata;
        p_l    = m_axis_tlast;
        p_done = 1'b0;
        if (hs && !rst) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("tdata", m_axis_tdata, e[63:0]);
                chk("tlast", {63'd0, m_axis_tlast}, {63'd0, e[64]});
                p_done = e[64];
                if (e[64]) ndone++;
            end
        end
        if (pop) begin
            if (m_idx == 0) m_len = (pkt_beats == 0) ? 1 : int'(pkt_beats);
            m_idx++;
            last = (m_idx == m_len);
            if (last) m_idx = 0;
            sb.push_back({last, fifo_m[0]});
            void'(fifo_m.pop_front());
            npop++;
        end
        @(negedge aclk);
        if (!rst) begin
            chk("pkt_done", {63'd0, pkt_done}, {63'd0, p_done});
            if (p_tv && !p_tr) begin
                chk("hold_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
                chk("hold_tdata", m_axis_tdata, p_d);
                chk("hold_tlast", {63'd0, m_axis_tlast}, {63'd0, p_l});
            end
        end
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((fifo_m.size() != 0 || sb.size() != 0 || m_axis_tvalid)
               && n < max_cyc) begin
            cycle();
            n++;
        end
        chk("drain_timeout", {63'd0, n >= max_cyc}, 64'd0);
    endtask

    task automatic do_reset();
        m_axis_tready = 1'b0;
        areset        = 1'b1;
        fifo_ready_rd = (fifo_m.size() != 0);
        #1;
        chk("rd_in_reset", {63'd0, fifo_rd}, 64'd0);
        cycle();
        areset = 1'b0;
        sb.delete();
        m_idx = 0;
        chk("rst_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tlast", {63'd0, m_axis_tlast}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, pkt_done}, 64'd0);
    endtask

    initial begin
        int d0, p0, pushed, n;
        areset        = 1'b1;
        m_axis_tready = 1'b0;
        fifo_ready_rd = 1'b0;
        fifo_data     = '0;
        pkt_beats     = 16'd4;
        @(negedge aclk);
        do_reset();

        // back-to-back packets of 4
        for (int i = 0; i < 8; i++) fifo_m.push_back(64'h10 + 64'(i));
        m_axis_tready = 1'b1;
        d0 = ndone;
        drain(100);
        chk("t1_done_cnt", 64'(ndone - d0), 64'd2);
        chk("t1_busy", {63'd0, busy}, 64'd0);

        // backpressure fills skid, fifo_rd must stop
        pkt_beats = 16'd3;
        for (int i = 0; i < 3; i++) fifo_m.push_back(64'hA0 + 64'(i));
        m_axis_tready = 1'b0;
        p0 = npop;
        cycle();
        chk("t2_lat_tvalid", {63'd0, m_axis_tvalid}, 64'd1);
        chk("t2_lat_tdata", m_axis_tdata, 64'hA0);
        for (int i = 0; i < 6; i++) cycle();
        chk("t2_rd_stall", {63'd0, fifo_rd}, 64'd0);
        chk("t2_pops", 64'(npop - p0), 64'd2);
        chk("t2_tdata", m_axis_tdata, 64'hA0);
        m_axis_tready = 1'b1;
        drain(100);

        // pkt_beats 0 -> single-beat packets
        pkt_beats = 16'd0;
        for (int i = 0; i < 4; i++) fifo_m.push_back(64'hB0 + 64'(i));
        d0 = ndone;
        drain(100);
        chk("t3_done_cnt", 64'(ndone - d0), 64'd4);

        // fifo runs dry mid-packet
        pkt_beats = 16'd5;
        fifo_m.push_back(64'hC0);
        fifo_m.push_back(64'hC1);
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 8; i++) begin
            chk("t4_gap_busy", {63'd0, busy}, 64'd1);
            chk("t4_gap_tvalid", {63'd0, m_axis_tvalid}, 64'd0);
            cycle();
        end
        for (int i = 2; i < 5; i++) fifo_m.push_back(64'hC0 + 64'(i));
        drain(100);
        chk("t4_busy_end", {63'd0, busy}, 64'd0);

        // reset mid-packet
        pkt_beats = 16'd4;
        fifo_m.push_back(64'hD0);
        fifo_m.push_back(64'hD1);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_busy_pre", {63'd0, busy}, 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) fifo_m.push_back(64'hE0 + 64'(i));
        m_axis_tready = 1'b1;
        d0 = ndone;
        drain(100);
        chk("t5_done_cnt", 64'(ndone - d0), 64'd1);

        // random backpressure and fill
        pkt_beats = 16'd7;
        pushed = 0;
        n = 0;
        d0 = ndone;
        while ((pushed < 1000 || fifo_m.size() != 0 || sb.size() != 0
                || m_axis_tvalid) && n < 20000) begin
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                fifo_m.push_back(64'hF000_0000_0000_0000 + 64'(pushed));
                pushed++;
            end
            m_axis_tready = ($urandom_range(0, 1) == 1);
            cycle();
            n++;
        end
        chk("t6_timeout", {63'd0, n >= 20000}, 64'd0);
        chk("t6_done_cnt", 64'(ndone - d0), 64'd142);
        chk("t6_busy", {63'd0, busy}, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
